// File: rtl/dec_ctrl_pkg.sv
// Shared types and helpers for the decoder round-robin arbiter.
//   NREQ / SEL_W : requester count and select width
//   arb_state_t  : arbiter FSM states
//   arb_out_t    : registered output bundle (grant, sel, busy, timeout)
//   onehot_of()  : 3-to-8 decode of a select code
package dec_ctrl_pkg;

    localparam int unsigned NREQ  = 8;
    localparam int unsigned SEL_W = 3;

    typedef logic [NREQ-1:0]  req_vec_t;
    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef struct packed {
        req_vec_t grant;
        sel_t     sel;
        logic     busy;
        logic     timeout;
    } arb_out_t;

    // Decode a select code to its one-hot enable.
    function automatic req_vec_t onehot_of(input sel_t sel);
        return req_vec_t'(1) << sel;
    endfunction

endpackage

// File: rtl/dec_rr_arbiter_if.sv
// Requester-side bus of the arbiter.
//   req, done            : driven by requesters (master)
//   grant, sel, busy,
//   timeout              : driven by the arbiter (slave)
interface dec_rr_arbiter_if;
    import dec_ctrl_pkg::*;

    req_vec_t req;
    req_vec_t done;
    req_vec_t grant;
    sel_t     sel;
    logic     busy;
    logic     timeout;

    modport master (
        output req, done,
        input  grant, sel, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, sel, busy, timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req_i        : request vector
//   last_owner_i : previous winner; search starts one above it
//   any_req_o    : at least one request pending
//   winner_o     : first set request found rotating upward
module rr_pick
    import dec_ctrl_pkg::*;
(
    input  req_vec_t req_i,
    input  sel_t     last_owner_i,
    output logic     any_req_o,
    output sel_t     winner_o
);

    assign any_req_o = |req_i;

    // Scan from the farthest position back to the nearest so the nearest set bit wins.
    always_comb begin
        sel_t idx;
        idx      = '0;
        winner_o = '0;
        for (int k = int'(NREQ); k > 0; k--) begin
            idx = last_owner_i + sel_t'(k);
            if (req_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter driving the shared 3-to-8 decoder select.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of dec_rr_arbiter_if
//                (req/done in; registered grant/sel/busy/timeout out)
//   TIMEOUT    : maximum grant length in cycles, 0 disables the watchdog
module dec_rr_arbiter
    import dec_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dec_rr_arbiter_if.slave   bus
);

    localparam int unsigned      CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    sel_t             last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    arb_out_t         out_q,   out_d;

    logic any_req;
    sel_t winner;
    logic owner_rel;
    logic wd_hit;

    rr_pick u_pick (
        .req_i        (bus.req),
        .last_owner_i (last_q),
        .any_req_o    (any_req),
        .winner_o     (winner)
    );

    // Owner finished or withdrew; takes precedence over the watchdog.
    assign owner_rel = bus.done[out_q.sel] || !bus.req[out_q.sel];
    assign wd_hit    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_d.timeout = 1'b0;

        case (state_q)
            IDLE, RELEASE: begin
                out_d.grant = '0;
                out_d.busy  = 1'b0;
                if (any_req) begin
                    state_d     = GRANT;
                    out_d.grant = onehot_of(winner);
                    out_d.sel   = winner;
                    out_d.busy  = 1'b1;
                    last_d      = winner;
                    cnt_d       = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (owner_rel || wd_hit) begin
                    state_d       = RELEASE;
                    out_d.grant   = '0;
                    out_d.busy    = 1'b0;
                    out_d.timeout = !owner_rel;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= sel_t'(NREQ - 1);
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign bus.grant   = out_q.grant;
    assign bus.sel     = out_q.sel;
    assign bus.busy    = out_q.busy;
    assign bus.timeout = out_q.timeout;

endmodule
